// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing NUM_REGS byte-strobed registers.
// Independent AW/W capture, one-cycle commit, and a separate single-beat read path.
module axi4_lite_slave_regs #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [2:0]              AWPROT,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [2:0]              ARPROT,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TOP_LSB  = ADDR_LSB + IDX_W;
  localparam logic [IDX_W:0] REG_COUNT = (IDX_W + 1)'(NUM_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, COMMIT, RESP} wstate_t;

  wstate_t                 state_reg;
  logic                    init_done_reg;
  logic                    aw_held_reg;
  logic                    w_held_reg;
  logic [IDX_W-1:0]        aw_idx_reg;
  logic                    aw_err_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [STRB_W-1:0]       wstrb_reg;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_err;
  logic             ar_err;
  logic             aw_hs;
  logic             w_hs;
  logic             ar_hs;
  logic             commit;

  // Any address outside the populated register window is decoded as an error.
  assign aw_idx = AWADDR[ADDR_LSB +: IDX_W];
  assign ar_idx = ARADDR[ADDR_LSB +: IDX_W];
  assign aw_err = ({1'b0, aw_idx} >= REG_COUNT) || (AWADDR[ADDR_WIDTH-1:TOP_LSB] != '0);
  assign ar_err = ({1'b0, ar_idx} >= REG_COUNT) || (ARADDR[ADDR_WIDTH-1:TOP_LSB] != '0);

  assign aw_hs  = AWVALID && AWREADY;
  assign w_hs   = WVALID && WREADY;
  assign ar_hs  = ARVALID && ARREADY;
  assign commit = (state_reg == COMMIT) && !aw_err_reg;

  logic unused;
  assign unused = ^{AWPROT, ARPROT, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) init_done_reg <= 1'b0;
    else          init_done_reg <= 1'b1;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg   <= IDLE;
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      aw_err_reg  <= 1'b0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      AWREADY     <= 1'b0;
      WREADY      <= 1'b0;
      BVALID      <= 1'b0;
      BRESP       <= RESP_OKAY;
    end else if (!init_done_reg) begin
      AWREADY <= 1'b1;
      WREADY  <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (aw_hs) begin
            aw_held_reg <= 1'b1;
            aw_idx_reg  <= aw_idx;
            aw_err_reg  <= aw_err;
            AWREADY     <= 1'b0;
          end
          if (w_hs) begin
            w_held_reg <= 1'b1;
            wdata_reg  <= WDATA;
            wstrb_reg  <= WSTRB;
            WREADY     <= 1'b0;
          end
          if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs))
            state_reg <= COMMIT;
        end
        COMMIT: begin
          BVALID      <= 1'b1;
          BRESP       <= aw_err_reg ? RESP_SLVERR : RESP_OKAY;
          aw_held_reg <= 1'b0;
          w_held_reg  <= 1'b0;
          state_reg   <= RESP;
        end
        RESP: begin
          if (BREADY) begin
            BVALID    <= 1'b0;
            AWREADY   <= 1'b1;
            WREADY    <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
          regs[gi] <= '0;
        end else if (commit && (aw_idx_reg == IDX_W'(gi))) begin
          for (int b = 0; b < STRB_W; b++)
            if (wstrb_reg[b]) regs[gi][b*8 +: 8] <= wdata_reg[b*8 +: 8];
        end
      end
    end
  endgenerate

  // Read data is sampled from the register bank before any same-edge commit lands.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= RESP_OKAY;
    end else if (!init_done_reg) begin
      ARREADY <= 1'b1;
    end else if (ar_hs) begin
      ARREADY <= 1'b0;
      RVALID  <= 1'b1;
      RDATA   <= ar_err ? '0 : regs[ar_idx];
      RRESP   <= ar_err ? RESP_SLVERR : RESP_OKAY;
    end else if (RVALID && RREADY) begin
      RVALID  <= 1'b0;
      ARREADY <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed plus randomized bench for axi4_lite_slave_regs against a simple register-array model.
module tb_axi4_lite_slave_regs;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic [2:0]  ARPROT;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [16];

  axi4_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Valid addresses are exactly the first 16 words of the address space.
  function automatic bit addr_ok(input logic [31:0] a);
    return (a / 4) < 16;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 32'h0;
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (addr_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model_mem[a / 4][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs;
    bit w_hs;
    int c = 0;
    logic [1:0] exp_resp;
    exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
    AWADDR = a;
    WDATA  = d;
    WSTRB  = s;
    while (!(aw_done && w_done) && c < 40) begin
      AWVALID = !aw_done && (c >= aw_dly);
      WVALID  = !w_done && (c >= w_dly);
      aw_hs   = AWVALID && AWREADY;
      w_hs    = WVALID && WREADY;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    AWVALID = 1'b0;
    WVALID  = 1'b0;
    check("wr_handshake", 64'(aw_done && w_done), 64'(1));
    check("wr_readies_low", 64'({AWREADY, WREADY}), 64'(0));
    check("bvalid_not_early", 64'(BVALID), 64'(0));
    tick();
    check("bvalid_rise", 64'(BVALID), 64'(1));
    check("bresp", 64'(BRESP), 64'(exp_resp));
    model_write(a, d, s);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      check("bvalid_hold", 64'(BVALID), 64'(1));
      check("bresp_hold", 64'(BRESP), 64'(exp_resp));
      check("awready_stall", 64'(AWREADY), 64'(0));
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check("bvalid_fall", 64'(BVALID), 64'(0));
    check("wr_readies_back", 64'({AWREADY, WREADY}), 64'(2'b11));
    $display("[TB] write addr=0x%08h data=0x%08h strb=0x%0h aw_dly=%0d w_dly=%0d b_dly=%0d",
             a, d, s, aw_dly, w_dly, b_dly);
  endtask

  task automatic do_read(input logic [31:0] a, input int r_dly, output logic [31:0] got);
    int c = 0;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    exp_data = addr_ok(a) ? model_mem[a / 4] : 32'h0;
    exp_resp = addr_ok(a) ? 2'b00 : 2'b10;
    ARADDR  = a;
    ARVALID = 1'b1;
    while (!ARREADY && c < 20) begin
      tick();
      c++;
    end
    check("arready_wait", 64'(ARREADY), 64'(1));
    tick();
    ARVALID = 1'b0;
    got = RDATA;
    check("rvalid_rise", 64'(RVALID), 64'(1));
    check("arready_drop", 64'(ARREADY), 64'(0));
    check("rdata", 64'(RDATA), 64'(exp_data));
    check("rresp", 64'(RRESP), 64'(exp_resp));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      check("rvalid_hold", 64'(RVALID), 64'(1));
      check("rdata_hold", 64'(RDATA), 64'(exp_data));
    end
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    check("rvalid_fall", 64'(RVALID), 64'(0));
    check("arready_back", 64'(ARREADY), 64'(1));
    $display("[TB] read  addr=0x%08h data=0x%08h resp=%0d", a, got, RRESP);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] d;
    int sel;
    int bvalid_seen;

    ARESETn = 1'b0;
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    model_clear();

    repeat (3) tick();
    check("rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    check("rst_valids", 64'({BVALID, RVALID}), 64'(0));
    check("rst_resps", 64'({BRESP, RRESP}), 64'(0));
    check("rst_rdata", 64'(RDATA), 64'(0));
    ARESETn = 1'b1;
    check("release_readies_pre_edge", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    tick();
    check("release_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));

    do_read(32'h0, 0, rd);
    check("reset_reg0", 64'(rd), 64'(32'h0));

    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(32'h04, 0, rd);
    check("full_write_readback", 64'(rd), 64'(32'hDEADBEEF));

    do_write(32'h04, 32'h12345678, 4'h3, 3, 0, 0);
    do_read(32'h04, 1, rd);
    check("w_first_strobed_readback", 64'(rd), 64'(32'hDEAD5678));

    do_write(32'h40, 32'hCAFEF00D, 4'hF, 0, 0, 0);
    do_read(32'h40, 0, rd);
    check("oob_read_data", 64'(rd), 64'(32'h0));
    do_read(32'h04, 0, rd);
    check("oob_no_side_effect", 64'(rd), 64'(32'hDEAD5678));

    do_write(32'h08, 32'h0BADCAFE, 4'hF, 1, 0, 5);
    do_write(32'h08, 32'hFFFFFFFF, 4'h0, 0, 2, 0);
    do_read(32'h0B, 2, rd);
    check("zero_strobe_unaligned", 64'(rd), 64'(32'h0BADCAFE));

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      else         a = $urandom;
      d = $urandom;
      do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      do_read(a, int'($urandom_range(0, 2)), rd);
    end

    do_write(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    AWADDR  = 32'h0C;
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    check("aw_only_ready_drop", 64'({AWREADY, WREADY}), 64'(2'b01));
    ARESETn = 1'b0;
    #1;
    check("async_rst_readies", 64'({AWREADY, WREADY, ARREADY}), 64'(0));
    model_clear();
    tick();
    tick();
    ARESETn = 1'b1;
    bvalid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (BVALID) bvalid_seen++;
    end
    check("discarded_aw_no_bvalid", 64'(bvalid_seen), 64'(0));
    do_read(32'h0C, 0, rd);
    check("reset_cleared_reg", 64'(rd), 64'(32'h0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
